// File: rtl/servant_uart_rx.sv
// servant_uart_rx: Wishbone-responder UART receiver for the servant SoC.
// Oversamples 8N1 frames on i_rx, buffers bytes in a small FIFO and raises
// o_irq while data is pending.
//
// Optional feature: define SERVANT_UART_RX_PARITY_EN to receive 8E1 frames.
// A PARITY state then sits between DATA and STOP, and a parity mismatch sets
// perr (status bit 4) and discards the byte. With the macro undefined the
// frame is 8N1 and status bit 4 always reads 0.
//
// Register map (only adr[2] decoded):
//   0x0 read : [8] not-empty, [7:0] FIFO head; pops when non-empty
//   0x4 read : [4] perr, [3] ferr, [2] ovr, [1] full, [0] not-empty
//   0x4 write: write-1-to-clear bits 4..2

`timescale 1ns/1ps

module servant_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 139,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst_n,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  input  logic        i_rx,
  output logic        o_irq
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Receiver state
  logic             rx_meta;
  logic             rx_s;
  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [7:0]       shreg;
  logic [7:0]       shreg_d;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_d;
  logic             armed;
  logic             armed_d;
  logic             par_bad;
  logic             par_bad_d;

  // Frame outcome strobes from the FSM
  logic             push_c;
  logic             ferr_set_c;
  logic             perr_set_c;

  // FIFO storage and pointers
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr_d;
  logic [PTR_W-1:0] rptr_d;
  logic             empty_c;
  logic             full_c;
  logic [7:0]       head_c;

  // Sticky status flags
  logic             ovr;
  logic             ferr;
  logic             perr;

  // Bus decode
  logic             wb_req_c;
  logic             rd_data_c;
  logic             clr_c;
  logic             pop_c;
  logic             push_ok_c;
  logic             ovr_set_c;
  logic [31:0]      rdt_c;

  // Address/data bits outside the decoded range are intentionally ignored
  logic             unused_bits;
  assign unused_bits = ^{i_wb_adr[31:3], i_wb_adr[1:0],
                         i_wb_dat[31:5], i_wb_dat[1:0]};

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // FSM and bit-timing register
  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      bit_idx <= '0;
      armed   <= 1'b1;
      par_bad <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      shreg   <= shreg_d;
      bit_idx <= bit_idx_d;
      armed   <= armed_d;
      par_bad <= par_bad_d;
    end
  end

  // Next-state logic: mid-bit sampling driven by a down-counter
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    shreg_d    = shreg;
    bit_idx_d  = bit_idx;
    armed_d    = armed;
    par_bad_d  = par_bad;
    push_c     = 1'b0;
    ferr_set_c = 1'b0;
    perr_set_c = 1'b0;

    case (state)
      IDLE: begin
        // After a framing error the line must return high before re-arming,
        // so a held break produces a single ferr rather than a frame stream.
        if (!armed) begin
          if (rx_s) begin
            armed_d = 1'b1;
          end
        end else if (!rx_s) begin
          cnt_d   = CNT_HALF;
          state_d = START;
        end
      end

      START: begin
        if (cnt != '0) begin
          cnt_d = cnt - CNT_W'(1);
        end else if (rx_s) begin
          state_d = IDLE;
        end else begin
          cnt_d     = CNT_FULL;
          bit_idx_d = '0;
          par_bad_d = 1'b0;
          state_d   = DATA;
        end
      end

      DATA: begin
        if (cnt != '0) begin
          cnt_d = cnt - CNT_W'(1);
        end else begin
          shreg_d   = {rx_s, shreg[7:1]};
          cnt_d     = CNT_FULL;
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef SERVANT_UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end

      PARITY: begin
`ifdef SERVANT_UART_RX_PARITY_EN
        if (cnt != '0) begin
          cnt_d = cnt - CNT_W'(1);
        end else begin
          cnt_d   = CNT_FULL;
          state_d = STOP;
          if (rx_s != ^shreg) begin
            par_bad_d  = 1'b1;
            perr_set_c = 1'b1;
          end
        end
`else
        state_d = IDLE;
`endif
      end

      STOP: begin
        if (cnt != '0) begin
          cnt_d = cnt - CNT_W'(1);
        end else begin
          // Return to IDLE at mid-stop so a back-to-back start bit is caught
          state_d = IDLE;
          if (!rx_s) begin
            ferr_set_c = 1'b1;
            armed_d    = 1'b0;
          end else if (!par_bad) begin
            push_c = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FIFO status, bus decode and push/pop arbitration
  always_comb begin
    empty_c   = (wptr == rptr);
    full_c    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    head_c    = mem[rptr[AW-1:0]];
    wb_req_c  = i_wb_cyc && !o_wb_ack;
    rd_data_c = wb_req_c && !i_wb_we && !i_wb_adr[2];
    clr_c     = wb_req_c && i_wb_we && i_wb_adr[2];
    pop_c     = rd_data_c && !empty_c;
    // A pop in the same cycle frees the slot, so push-on-full is accepted
    push_ok_c = push_c && (!full_c || pop_c);
    ovr_set_c = push_c && full_c && !pop_c;
    wptr_d    = wptr + PTR_W'(push_ok_c);
    rptr_d    = rptr + PTR_W'(pop_c);
  end

  // Read data mux, valid in the ack cycle
  always_comb begin
    rdt_c = '0;
    if (i_wb_adr[2]) begin
      rdt_c[4:0] = {perr, ferr, ovr, full_c, !empty_c};
    end else if (!empty_c) begin
      rdt_c[8:0] = {1'b1, head_c};
    end
  end

  // FIFO storage; contents need no reset since pointers gate visibility
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst_n && push_ok_c) begin
      mem[wptr[AW-1:0]] <= shreg;
    end
  end

  // FIFO pointers, sticky flags, interrupt and Wishbone response
  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      ovr      <= 1'b0;
      ferr     <= 1'b0;
      perr     <= 1'b0;
      o_irq    <= 1'b0;
      o_wb_ack <= 1'b0;
      o_wb_rdt <= '0;
    end else begin
      wptr     <= wptr_d;
      rptr     <= rptr_d;
      // A new event in the clearing cycle wins so it is never lost
      ovr      <= (ovr  && !(clr_c && i_wb_dat[2])) || ovr_set_c;
      ferr     <= (ferr && !(clr_c && i_wb_dat[3])) || ferr_set_c;
      perr     <= (perr && !(clr_c && i_wb_dat[4])) || perr_set_c;
      o_irq    <= (wptr_d != rptr_d);
      o_wb_ack <= wb_req_c;
      o_wb_rdt <= (wb_req_c && !i_wb_we) ? rdt_c : '0;
    end
  end

endmodule

// File: doc/servant_uart_rx.md
Name: servant_uart_rx

Overview:
- Wishbone-responder UART receiver peripheral for the servant SoC.
- Complements the bit-banged serial output on q: it accepts 8N1 serial frames on a pin, oversamples them, and buffers received bytes in a small FIFO.
- The CPU reads bytes and status through a slot on servant_mux, alongside gpio and timer.
- Provides a level interrupt while data is pending.

Parameters:
- CLKS_PER_BIT, 139, wb_clk cycles per bit (16 MHz / 115200); minimum 4.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, minimum 2.

Ports:
- i_wb_clk  in  1  system clock; all logic on rising edge.
- i_wb_rst_n  in  1  reset, synchronous and active-low.
- i_wb_adr  in  32  byte address; only bit 2 decoded.
- i_wb_dat  in  32  write data.
- i_wb_we  in  1  write enable.
- i_wb_cyc  in  1  cycle/strobe.
- o_wb_rdt  out  32  read data.
- o_wb_ack  out  1  single-cycle acknowledge.
- i_rx  in  1  asynchronous serial input; idle high.
- o_irq  out  1  high while the FIFO is non-empty.

Behaviour:
- Reset (i_wb_rst_n=0 at clock edge):
  - FSM goes to IDLE; FIFO is emptied; sticky flags are cleared.
  - Synchronizer flops are set to 1.
  - o_wb_ack=0, o_wb_rdt=0, o_irq=0.
  - Reset mid-frame abandons the frame; the next falling edge after reset starts a new frame.
- Input sync: two flops on i_rx; rx_s is the second flop. All decoding uses rx_s.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: rx_s=0 loads the counter with CLKS_PER_BIT/2-1 and moves to START.
  - START: at counter 0, sample rx_s.
    - rx_s=1: false start; return to IDLE.
    - rx_s=0: reload the counter with CLKS_PER_BIT-1 and move to DATA.
  - DATA: sample at each counter expiry, 8 bits, LSB first, shifted into the shift register. After bit 7, move to STOP (or PARITY, see Optional Feature).
  - STOP: sample at counter expiry.
    - rx_s=0: set framing error (ferr); discard the byte.
    - rx_s=1: push the byte if the FIFO is not full; if full, set overrun (ovr) and drop the new byte, keeping FIFO contents.
    - Either way, return to IDLE in the same cycle, i.e. at mid-stop, ready for a back-to-back start bit.
  - After a framing error, the FSM waits in IDLE for rx_s=1 before arming again. A break condition yields one ferr, not repeated frames.
- Latency: byte visible (o_irq=1) one cycle after the mid-stop sample. From an i_rx falling edge this is 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles, ±1.
- Wishbone:
  - o_wb_ack=1 in the cycle after i_wb_cyc=1 while o_wb_ack=0, i.e. one-cycle ack, never back-to-back. o_wb_rdt is valid in the ack cycle.
  - adr[2]=0 read: rdt[7:0]=FIFO head, rdt[8]=not-empty, rest 0. Pops the head if non-empty. Read when empty returns 0 and does not pop.
  - adr[2]=1 read: bit0 not-empty, bit1 full, bit2 ovr, bit3 ferr, bit4 perr, rest 0. No side effect.
  - adr[2]=1 write: write-1-to-clear bits 2..4.
  - adr[2]=0 write: ignored.
- Simultaneous push and pop in one cycle: both take effect; count unchanged. Pop-on-full plus push never raises ovr.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits; wrap is natural.
- o_irq is registered equal to not-empty.

Optional Feature:
- Macro SERVANT_UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP and samples one even-parity bit.
  - On mismatch, perr is set and the byte is discarded, even if the stop bit is good.
  - Frame is 8E1; latency grows by CLKS_PER_BIT.
- Undefined:
  - No PARITY state; status bit4 reads 0.
  - Frame is 8N1.

Test Plan:
- CLKS_PER_BIT=16. Send 0xA5 8N1 -> o_irq rises 2+8+144(±1) cycles after the edge; read adr 0x0 returns 0x1A5; o_irq=0; status reads 0x0.
- Glitch low on i_rx for 3 cycles -> false start; no push, no flags, FSM back in IDLE.
- Send 5 bytes 0x01..0x05 back-to-back with no reads, FIFO_DEPTH=4 -> status=0x07 (not-empty, full, ovr); reads return 0x101..0x104, then 0x000. Write 0x4 to 0x4 -> ovr cleared.
- Byte 0x3C with stop bit driven 0 -> ferr=1, FIFO empty. Line held low 40 bit-times -> ferr still set, no push. Line released then 0x3C sent -> 0x13C read back.
- Data read on the same cycle as a stop-bit push with FIFO full -> count stays 4, ovr=0, ordering preserved.
- Assert reset mid-DATA of 0xFF, deassert, send 0x42 -> only 0x42 received, all flags 0. With PARITY_EN: 0x42 with parity bit=1 -> perr=1, FIFO empty.
